stopwatch_btn_ctrl: RTL and testbench

STOPWATCH_BTN_CTRL -- requirements
Module: stopwatch_btn_ctrl

---
 rtl/sw_pkg.sv | 19 +
 rtl/stopwatch_btn_ctrl_if.sv | 10 +
 rtl/btn_debounce.sv | 76 +++++++
 rtl/stopwatch_btn_ctrl.sv | 78 +++++++
 tb/tb_stopwatch_btn_ctrl.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/sw_pkg.sv
// Shared types and defaults for the stopwatch button controller.
package sw_pkg;

    localparam int DB_TICKS_DEF   = 1000000;   // 20 ms at 50 MHz
    localparam int HOLD_TICKS_DEF = 50000000;  // 1 s at 50 MHz

    typedef enum logic [1:0] {
        ZERO  = 2'd0,
        WAIT1 = 2'd1,
        ONE   = 2'd2,
        WAIT0 = 2'd3
    } db_state_e;

    // One counter width serves both debounce and hold windows so neither can wrap.
    function automatic int cnt_width(input int a, input int b);
        return (a > b) ? $clog2(a) : $clog2(b);
    endfunction

endpackage

// File: rtl/stopwatch_btn_ctrl_if.sv
// Button-in / control-out bundle between the board buttons and the stopwatch core.
interface stopwatch_btn_ctrl_if;
    logic [1:0] btn;  // raw pushbuttons: [1] start/stop, [0] clear
    logic       go;
    logic       clr;
    logic [1:0] db;

    modport master (output btn, input go, clr, db);
    modport slave  (input btn, output go, clr, db);
endinterface

// File: rtl/btn_debounce.sv
// One pushbutton: 2-flop synchronizer, four-state debounce FSM, debounced level
// and a one-cycle press tick on the WAIT1 -> ONE transition only.
module btn_debounce
    import sw_pkg::*;
#(
    parameter int DB_TICKS = DB_TICKS_DEF,
    parameter int CW       = cnt_width(DB_TICKS_DEF, HOLD_TICKS_DEF)
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic db,
    output logic tick
);

    localparam logic [CW-1:0] LAST = CW'(DB_TICKS - 1);

    logic [1:0]    sync;
    logic          in_s;
    db_state_e     state;
    logic [CW-1:0] cnt;

    assign in_s = sync[1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync  <= 2'b00;
            state <= ZERO;
            cnt   <= '0;
            db    <= 1'b0;
            tick  <= 1'b0;
        end else begin
            sync <= {sync[0], btn_raw};
            tick <= 1'b0;
            case (state)
                ZERO: begin
                    if (in_s) begin
                        state <= WAIT1;
                        cnt   <= '0;
                    end
                end
                WAIT1: begin
                    // a dropout restarts the window; the counter stops at LAST
                    if (!in_s) begin
                        state <= ZERO;
                    end else if (cnt == LAST) begin
                        state <= ONE;
                        db    <= 1'b1;
                        tick  <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ONE: begin
                    if (!in_s) begin
                        state <= WAIT0;
                        cnt   <= '0;
                    end
                end
                WAIT0: begin
                    // bounce on release returns to ONE silently (no second tick)
                    if (in_s) begin
                        state <= ONE;
                    end else if (cnt == LAST) begin
                        state <= ZERO;
                        db    <= 1'b0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= ZERO;
            endcase
        end
    end

endmodule

// File: rtl/stopwatch_btn_ctrl.sv
// Stopwatch button controller: debounced start/stop toggles go, clear pulses clr.
// Build option SW_CLR_HOLD_EN: clr comes from a long press (HOLD_TICKS) of btn[0].
module stopwatch_btn_ctrl
    import sw_pkg::*;
#(
    parameter int DB_TICKS   = DB_TICKS_DEF,
    parameter int HOLD_TICKS = HOLD_TICKS_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    stopwatch_btn_ctrl_if.slave  sw
);

    localparam int CW = cnt_width(DB_TICKS, HOLD_TICKS);

    logic [1:0] tick;
    logic [1:0] db;
    logic       clr_q;
    logic       go_q;

    for (genvar i = 0; i < 2; i++) begin : g_btn
        btn_debounce #(
            .DB_TICKS (DB_TICKS),
            .CW       (CW)
        ) u_db (
            .clk     (clk),
            .reset   (reset),
            .btn_raw (sw.btn[i]),
            .db      (db[i]),
            .tick    (tick[i])
        );
    end

`ifdef SW_CLR_HOLD_EN
    logic [CW-1:0] hold_cnt;
    logic          hold_done;

    // hold_done blocks re-firing until the button is released
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_cnt  <= '0;
            hold_done <= 1'b0;
            clr_q     <= 1'b0;
        end else begin
            clr_q <= 1'b0;
            if (!db[0]) begin
                hold_cnt  <= '0;
                hold_done <= 1'b0;
            end else if (!hold_done) begin
                if (hold_cnt == CW'(HOLD_TICKS - 1)) begin
                    clr_q     <= 1'b1;
                    hold_done <= 1'b1;
                end else begin
                    hold_cnt <= hold_cnt + CW'(1);
                end
            end
        end
    end
`else
    assign clr_q = tick[0];
`endif

    // clear has priority over a coincident start/stop press
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            go_q <= 1'b0;
        end else if (clr_q) begin
            go_q <= 1'b0;
        end else if (tick[1]) begin
            go_q <= ~go_q;
        end
    end

    assign sw.go  = go_q;
    assign sw.clr = clr_q;
    assign sw.db  = db;

endmodule

// File: tb/tb_stopwatch_btn_ctrl.sv
// Directed bench for stopwatch_btn_ctrl with DB_TICKS=4, HOLD_TICKS=10.
module tb_stopwatch_btn_ctrl;

    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    stopwatch_btn_ctrl_if sw_if ();

    stopwatch_btn_ctrl #(
        .DB_TICKS   (4),
        .HOLD_TICKS (10)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .sw    (sw_if.slave)
    );

    always #5 clk = ~clk;

    // advance n rising edges, then settle 1 time unit past the last one
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press_release(input logic [1:0] b);
        sw_if.btn = b;
        step(8);
        sw_if.btn = 2'b00;
        step(10);
    endtask

    task automatic test_reset;
        reset     = 1'b1;
        sw_if.btn = 2'b00;
        step(3);
        n_tests++;
        if (sw_if.go !== 1'b0) begin n_fail++; $display("FAIL reset_go: got %b want 0", sw_if.go); end
        n_tests++;
        if (sw_if.clr !== 1'b0) begin n_fail++; $display("FAIL reset_clr: got %b want 0", sw_if.clr); end
        n_tests++;
        if (sw_if.db !== 2'b00) begin n_fail++; $display("FAIL reset_db: got %b want 00", sw_if.db); end
        reset = 1'b0;
        step(2);
    endtask

    task automatic test_clean_press;
        sw_if.btn = 2'b10;
        step(6);  // edges 0..5
        n_tests++;
        if (sw_if.db[1] !== 1'b0) begin n_fail++; $display("FAIL clean_db_early: got %b want 0", sw_if.db[1]); end
        step(1);  // edge 6: enters ONE, tick
        n_tests++;
        if (sw_if.db[1] !== 1'b1) begin n_fail++; $display("FAIL clean_db_e6: got %b want 1", sw_if.db[1]); end
        n_tests++;
        if (sw_if.go !== 1'b0) begin n_fail++; $display("FAIL clean_go_e6: got %b want 0", sw_if.go); end
        step(1);  // edge 7
        n_tests++;
        if (sw_if.go !== 1'b1) begin n_fail++; $display("FAIL clean_go_e7: got %b want 1", sw_if.go); end
        sw_if.btn = 2'b00;
        step(10);
        n_tests++;
        if ({sw_if.go, sw_if.db} !== 3'b100) begin n_fail++; $display("FAIL clean_release: got go,db=%b want 100", {sw_if.go, sw_if.db}); end
        sw_if.btn = 2'b10;
        step(7);
        n_tests++;
        if (sw_if.go !== 1'b1) begin n_fail++; $display("FAIL second_go_e6: got %b want 1", sw_if.go); end
        step(1);
        n_tests++;
        if (sw_if.go !== 1'b0) begin n_fail++; $display("FAIL second_go_e7: got %b want 0", sw_if.go); end
        sw_if.btn = 2'b00;
        step(10);
    endtask

    task automatic test_bounce;
        logic [5:0] pat;
        pat = 6'b011011;  // sampled LSB first: 1,1,0,1,1,0
        for (int k = 0; k < 6; k++) begin
            sw_if.btn = {pat[k], 1'b0};
            step(1);
        end
        sw_if.btn = 2'b10;  // last rising sample is the next edge
        step(6);
        n_tests++;
        if ({sw_if.go, sw_if.db[1]} !== 2'b00) begin n_fail++; $display("FAIL bounce_early: got go,db1=%b want 00", {sw_if.go, sw_if.db[1]}); end
        step(1);
        n_tests++;
        if ({sw_if.go, sw_if.db[1]} !== 2'b01) begin n_fail++; $display("FAIL bounce_e6: got go,db1=%b want 01", {sw_if.go, sw_if.db[1]}); end
        step(1);
        n_tests++;
        if (sw_if.go !== 1'b1) begin n_fail++; $display("FAIL bounce_e7: got %b want 1", sw_if.go); end
        step(6);
        n_tests++;
        if (sw_if.go !== 1'b1) begin n_fail++; $display("FAIL bounce_single: got %b want 1", sw_if.go); end
        sw_if.btn = 2'b00;
        step(10);
    endtask

    task automatic test_clear;
        // go is 1 on entry
        sw_if.btn = 2'b01;
        step(6);
        n_tests++;
        if (sw_if.clr !== 1'b0) begin n_fail++; $display("FAIL clear_early: got %b want 0", sw_if.clr); end
        step(1);
        n_tests++;
        if ({sw_if.clr, sw_if.go} !== 2'b11) begin n_fail++; $display("FAIL clear_pulse: got clr,go=%b want 11", {sw_if.clr, sw_if.go}); end
        step(1);
        n_tests++;
        if ({sw_if.clr, sw_if.go} !== 2'b00) begin n_fail++; $display("FAIL clear_after: got clr,go=%b want 00", {sw_if.clr, sw_if.go}); end
        sw_if.btn = 2'b00;
        step(10);
        n_tests++;
        if ({sw_if.clr, sw_if.go} !== 2'b00) begin n_fail++; $display("FAIL clear_release: got clr,go=%b want 00", {sw_if.clr, sw_if.go}); end
    endtask

    task automatic test_simultaneous;
        press_release(2'b10);  // go -> 1
        n_tests++;
        if (sw_if.go !== 1'b1) begin n_fail++; $display("FAIL simul_setup: got %b want 1", sw_if.go); end
        sw_if.btn = 2'b11;
        step(7);
        n_tests++;
        if (sw_if.clr !== 1'b1) begin n_fail++; $display("FAIL simul_clr: got %b want 1", sw_if.clr); end
        step(1);
        n_tests++;
        if ({sw_if.clr, sw_if.go} !== 2'b00) begin n_fail++; $display("FAIL simul_go: got clr,go=%b want 00", {sw_if.clr, sw_if.go}); end
        step(4);
        n_tests++;
        if (sw_if.go !== 1'b0) begin n_fail++; $display("FAIL simul_hold: got %b want 0", sw_if.go); end
        sw_if.btn = 2'b00;
        step(10);
    endtask

    task automatic test_reset_mid;
        press_release(2'b10);  // go -> 1
        sw_if.btn = 2'b10;
        step(4);  // FSM mid-WAIT1
        reset = 1'b1;
        #1;
        n_tests++;
        if ({sw_if.go, sw_if.clr, sw_if.db} !== 4'b0000) begin n_fail++; $display("FAIL rstmid_async: got go,clr,db=%b want 0000", {sw_if.go, sw_if.clr, sw_if.db}); end
        step(2);
        reset = 1'b0;  // next edge is edge 0 with btn held
        step(6);
        n_tests++;
        if ({sw_if.go, sw_if.db[1]} !== 2'b00) begin n_fail++; $display("FAIL rstmid_early: got go,db1=%b want 00", {sw_if.go, sw_if.db[1]}); end
        step(1);
        n_tests++;
        if ({sw_if.go, sw_if.db[1]} !== 2'b01) begin n_fail++; $display("FAIL rstmid_e6: got go,db1=%b want 01", {sw_if.go, sw_if.db[1]}); end
        step(1);
        n_tests++;
        if (sw_if.go !== 1'b1) begin n_fail++; $display("FAIL rstmid_e7: got %b want 1", sw_if.go); end
        step(6);
        n_tests++;
        if (sw_if.go !== 1'b1) begin n_fail++; $display("FAIL rstmid_single: got %b want 1", sw_if.go); end
        sw_if.btn = 2'b00;
        step(10);
    endtask

    task automatic test_hold;
        int pulses;
        pulses = 0;
        sw_if.btn = 2'b01;
        for (int k = 0; k < 30; k++) begin
            if (k == 8) sw_if.btn = 2'b00;
            step(1);
            if (sw_if.clr === 1'b1) pulses++;
        end
        n_tests++;
        if (pulses !== 0) begin n_fail++; $display("FAIL hold_short: got %0d clr pulses want 0", pulses); end
        pulses = 0;
        sw_if.btn = 2'b01;
        for (int k = 0; k < 40; k++) begin
            if (k == 20) sw_if.btn = 2'b00;
            step(1);
            if (sw_if.clr === 1'b1) pulses++;
            if (k == 15) begin
                n_tests++;
                if (sw_if.clr !== 1'b0) begin n_fail++; $display("FAIL hold_e15: got %b want 0", sw_if.clr); end
            end
            if (k == 16) begin
                n_tests++;
                if (sw_if.clr !== 1'b1) begin n_fail++; $display("FAIL hold_e16: got %b want 1", sw_if.clr); end
            end
        end
        n_tests++;
        if (pulses !== 1) begin n_fail++; $display("FAIL hold_long: got %0d clr pulses want 1", pulses); end
    endtask

    initial begin
        reset     = 1'b1;
        sw_if.btn = 2'b00;
        test_reset;
        test_clean_press;
        test_bounce;
`ifdef SW_CLR_HOLD_EN
        test_hold;
`else
        test_clear;
        test_simultaneous;
`endif
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
